entrada_decimal: RTL and testbench

- Decimal digit-entry block; it is the input-side counterpart of the PC/value display path.
- Accepts BCD digits one at a time from keys or switches and keeps an echo buffer for the 7-segment decoders.
- On confirm, converts the entered decimal number to a 32-bit binary value, using a sequential multiply-by-10-and-add, and presents it to the datapath.

---
 rtl/entrada_decimal.sv | 144 ++++++++++++++
 tb/tb_entrada_decimal.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/entrada_decimal.sv
// Decimal digit-entry block: collects BCD digits into an echo buffer and,
// on confirm, converts them to a 32-bit binary value by multiply-by-10-and-add.
module entrada_decimal #(
  parameter int N_DIGITOS = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [3:0]             digito,
  input  logic                   digito_valido,
  input  logic                   apaga,
  input  logic                   limpa,
  input  logic                   confirma,
  output logic [4*N_DIGITOS-1:0] digitos,
  output logic [3:0]             contagem,
  output logic                   ocupado,
  output logic [31:0]            valor,
  output logic                   valor_valido,
  output logic                   erro
);

  localparam int DW = 4 * N_DIGITOS;
  localparam int IW = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;

  typedef enum logic [1:0] {
    ENTRADA  = 2'd0,
    CONVERTE = 2'd1,
    PRONTO   = 2'd2
  } estado_t;

  estado_t         estado, estado_next;
  logic [DW-1:0]   digitos_next;
  logic [3:0]      contagem_next;
  logic [31:0]     acumulador, acumulador_next;
  logic [IW-1:0]   indice, indice_next;
  logic [31:0]     valor_next;
  logic            valor_valido_next;
  logic            erro_next;
  logic [3:0]      nibble;

  // Digit currently being folded into the accumulator (most significant first).
  assign nibble  = 4'(digitos >> {indice, 2'b00});
  assign ocupado = (estado != ENTRADA);

  // State and datapath registers; reset is synchronous and active-low.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (!reset) begin
      estado       <= ENTRADA;
      digitos      <= '0;
      contagem     <= '0;
      acumulador   <= '0;
      indice       <= '0;
      valor        <= '0;
      valor_valido <= 1'b0;
      erro         <= 1'b0;
    end else begin
      estado       <= estado_next;
      digitos      <= digitos_next;
      contagem     <= contagem_next;
      acumulador   <= acumulador_next;
      indice       <= indice_next;
      valor        <= valor_next;
      valor_valido <= valor_valido_next;
      erro         <= erro_next;
    end
  end

  // Next-state and next-datapath logic with request priority limpa > confirma > apaga > digito.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    estado_next       = estado;
    digitos_next      = digitos;
    contagem_next     = contagem;
    acumulador_next   = acumulador;
    indice_next       = indice;
    valor_next        = valor;
    valor_valido_next = 1'b0;
    erro_next         = 1'b0;

    case (estado)
      ENTRADA: begin
        if (limpa) begin
          digitos_next  = '0;
          contagem_next = '0;
        end else if (confirma) begin
          if (contagem != 4'd0) begin
            acumulador_next = '0;
            indice_next     = IW'(N_DIGITOS - 1);
            estado_next     = CONVERTE;
          end else begin
            erro_next = 1'b1;
          end
        end else if (apaga) begin
          // Backspace on an empty buffer is a silent no-op.
          if (contagem != 4'd0) begin
            digitos_next  = digitos >> 4;
            contagem_next = contagem - 4'd1;
          end
        end else if (digito_valido) begin
          if (digito <= 4'd9 && contagem < 4'(N_DIGITOS)) begin
            digitos_next  = (digitos << 4) | DW'(digito);
            contagem_next = contagem + 4'd1;
          end else begin
            erro_next = 1'b1;
          end
        end
      end

      CONVERTE: begin
        if (limpa) begin
          digitos_next  = '0;
          contagem_next = '0;
          estado_next   = ENTRADA;
        end else begin
          // acc*10 + nibble as acc*8 + acc*2; at most 9 digits so it never overflows.
          acumulador_next = {acumulador[28:0], 3'b000}
                          + {acumulador[30:0], 1'b0}
                          + {28'd0, nibble};
          if (indice == '0) begin
            estado_next = PRONTO;
          end else begin
            indice_next = indice - 1'b1;
          end
        end
      end

      PRONTO: begin
        digitos_next  = '0;
        contagem_next = '0;
        estado_next   = ENTRADA;
        // An abort here discards the result: no commit, no pulse.
        if (!limpa) begin
          valor_next        = acumulador;
          valor_valido_next = 1'b1;
        end
      end

      default: begin
        estado_next = ENTRADA;
      end
    endcase
  end

endmodule

// File: tb/tb_entrada_decimal.sv
// Directed self-checking bench for entrada_decimal (N_DIGITOS = 4).
module tb_entrada_decimal;

  logic        clock;
  logic        reset;
  logic [3:0]  digito;
  logic        digito_valido;
  logic        apaga;
  logic        limpa;
  logic        confirma;
  logic [15:0] digitos;
  logic [3:0]  contagem;
  logic        ocupado;
  logic [31:0] valor;
  logic        valor_valido;
  logic        erro;

  int tests;
  int fails;

  entrada_decimal #(.N_DIGITOS(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .digito       (digito),
    .digito_valido(digito_valido),
    .apaga        (apaga),
    .limpa        (limpa),
    .confirma     (confirma),
    .digitos      (digitos),
    .contagem     (contagem),
    .ocupado      (ocupado),
    .valor        (valor),
    .valor_valido (valor_valido),
    .erro         (erro)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One rising edge; outputs are then observed 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    digito = d; digito_valido = 1'b1;
    tick();
    digito_valido = 1'b0;
  endtask

  task automatic do_confirma();
    confirma = 1'b1; tick(); confirma = 1'b0;
  endtask

  task automatic do_apaga();
    apaga = 1'b1; tick(); apaga = 1'b0;
  endtask

  task automatic do_limpa();
    limpa = 1'b1; tick(); limpa = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tests++; if (digitos !== 16'h0) begin fails++; $display("FAIL reset_digitos got %h want 0", digitos); end
    tests++; if (contagem !== 4'd0) begin fails++; $display("FAIL reset_contagem got %0d want 0", contagem); end
    tests++; if (valor !== 32'd0) begin fails++; $display("FAIL reset_valor got %0d want 0", valor); end
    tests++; if ({valor_valido, erro, ocupado} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {valor_valido, erro, ocupado}); end
  endtask

  // Enter a number, confirm, then watch N+1 edges for the single commit pulse.
  task automatic convert_and_check(input string name, input logic [15:0] exp_buf,
                                   input logic [3:0] exp_cnt, input logic [31:0] old_val,
                                   input logic [31:0] exp_val);
    int pulses;
    tests++; if (digitos !== exp_buf) begin fails++; $display("FAIL %s_buffer got %h want %h", name, digitos, exp_buf); end
    tests++; if (contagem !== exp_cnt) begin fails++; $display("FAIL %s_contagem got %0d want %0d", name, contagem, exp_cnt); end
    do_confirma();
    tests++; if (ocupado !== 1'b1 || digitos !== exp_buf) begin fails++; $display("FAIL %s_busy ocupado %b digitos %h want 1 %h", name, ocupado, digitos, exp_buf); end
    pulses = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (valor_valido) pulses++;
      tests++; if (valor !== old_val) begin fails++; $display("FAIL %s_hold_%0d valor %0d want %0d", name, k, valor, old_val); end
    end
    tick();
    tests++; if (valor !== exp_val || valor_valido !== 1'b1) begin fails++; $display("FAIL %s_commit valor %0d vv %b want %0d 1", name, valor, valor_valido, exp_val); end
    if (valor_valido) pulses++;
    tests++; if (contagem !== 4'd0 || digitos !== 16'h0 || ocupado !== 1'b0) begin fails++; $display("FAIL %s_after cnt %0d dig %h busy %b want 0 0 0", name, contagem, digitos, ocupado); end
    tick();
    if (valor_valido) pulses++;
    tests++; if (pulses !== 1) begin fails++; $display("FAIL %s_pulses got %0d want 1", name, pulses); end
    tests++; if (valor !== exp_val) begin fails++; $display("FAIL %s_keep valor %0d want %0d", name, valor, exp_val); end
  endtask

  task automatic test_convert_1234();
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    convert_and_check("c1234", 16'h1234, 4'd4, 32'd0, 32'd1234);
  endtask

  task automatic test_leading_zeros();
    press(4'd0); press(4'd0); press(4'd7);
    convert_and_check("c007", 16'h0007, 4'd3, 32'd1234, 32'd7);
  endtask

  task automatic test_apaga_full();
    do_apaga();
    tests++; if (erro !== 1'b0 || contagem !== 4'd0) begin fails++; $display("FAIL apaga_empty erro %b cnt %0d want 0 0", erro, contagem); end
    press(4'd9); press(4'd8); press(4'd7);
    do_apaga();
    tests++; if (digitos !== 16'h0098 || contagem !== 4'd2) begin fails++; $display("FAIL apaga_shift dig %h cnt %0d want 0098 2", digitos, contagem); end
    press(4'd5);
    tests++; if (digitos !== 16'h0985 || contagem !== 4'd3) begin fails++; $display("FAIL apaga_enter dig %h cnt %0d want 0985 3", digitos, contagem); end
    press(4'd1);
    tests++; if (erro !== 1'b0 || digitos !== 16'h9851) begin fails++; $display("FAIL fill erro %b dig %h want 0 9851", erro, digitos); end
    press(4'd2);
    tests++; if (erro !== 1'b1 || digitos !== 16'h9851 || contagem !== 4'd4) begin fails++; $display("FAIL full_reject erro %b dig %h cnt %0d want 1 9851 4", erro, digitos, contagem); end
    tick();
    tests++; if (erro !== 1'b0) begin fails++; $display("FAIL full_pulse erro %b want 0", erro); end
    do_limpa();
    tests++; if (digitos !== 16'h0 || contagem !== 4'd0) begin fails++; $display("FAIL limpa dig %h cnt %0d want 0 0", digitos, contagem); end
  endtask

  task automatic test_errors();
    press(4'd3);
    press(4'hA);
    tests++; if (erro !== 1'b1 || digitos !== 16'h0003 || contagem !== 4'd1) begin fails++; $display("FAIL bad_digit erro %b dig %h cnt %0d want 1 0003 1", erro, digitos, contagem); end
    do_limpa();
    do_confirma();
    tests++; if (erro !== 1'b1 || ocupado !== 1'b0) begin fails++; $display("FAIL empty_confirm erro %b busy %b want 1 0", erro, ocupado); end
    tick();
    tests++; if (erro !== 1'b0 || ocupado !== 1'b0) begin fails++; $display("FAIL empty_confirm_after erro %b busy %b want 0 0", erro, ocupado); end
  endtask

  task automatic test_abort();
    int pulses;
    press(4'd4); press(4'd2);
    do_confirma();
    tick();
    do_limpa();
    tests++; if (ocupado !== 1'b0 || contagem !== 4'd0 || digitos !== 16'h0) begin fails++; $display("FAIL abort_state busy %b cnt %0d dig %h want 0 0 0", ocupado, contagem, digitos); end
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      if (valor_valido) pulses++;
      tick();
    end
    tests++; if (pulses !== 0 || valor !== 32'd7) begin fails++; $display("FAIL abort_value pulses %0d valor %0d want 0 7", pulses, valor); end
  endtask

  task automatic test_priority();
    press(4'd3);
    digito = 4'd5; digito_valido = 1'b1; limpa = 1'b1;
    tick();
    digito_valido = 1'b0; limpa = 1'b0;
    tests++; if (digitos !== 16'h0 || contagem !== 4'd0) begin fails++; $display("FAIL limpa_wins dig %h cnt %0d want 0 0", digitos, contagem); end
    press(4'd6);
    apaga = 1'b1; confirma = 1'b1;
    tick();
    apaga = 1'b0; confirma = 1'b0;
    tests++; if (ocupado !== 1'b1 || digitos !== 16'h0006) begin fails++; $display("FAIL confirma_wins busy %b dig %h want 1 0006", ocupado, digitos); end
    do_limpa();
  endtask

  task automatic test_back_to_back();
    int pulses;
    press(4'd9); press(4'd9); press(4'd9); press(4'd9);
    do_confirma();
    press(4'd3);
    tests++; if (erro !== 1'b0 || digitos !== 16'h9999) begin fails++; $display("FAIL busy_ignore erro %b dig %h want 0 9999", erro, digitos); end
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (valor_valido) pulses++;
    end
    tests++; if (pulses !== 1 || valor !== 32'd9999) begin fails++; $display("FAIL b2b_first pulses %0d valor %0d want 1 9999", pulses, valor); end
    press(4'd5); press(4'd0);
    convert_and_check("c50", 16'h0050, 4'd2, 32'd9999, 32'd50);
  endtask

  task automatic test_reset_mid();
    int pulses;
    press(4'd5);
    do_confirma();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tests++; if (digitos !== 16'h0 || contagem !== 4'd0 || valor !== 32'd0 || {ocupado, valor_valido, erro} !== 3'b000) begin
      fails++; $display("FAIL reset_mid dig %h cnt %0d valor %0d flags %b want all 0", digitos, contagem, valor, {ocupado, valor_valido, erro});
    end
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (valor_valido) pulses++;
    end
    tests++; if (pulses !== 0) begin fails++; $display("FAIL reset_mid_pulse got %0d want 0", pulses); end
  endtask

  initial begin
    tests = 0; fails = 0;
    reset = 1'b1; digito = 4'd0; digito_valido = 1'b0;
    apaga = 1'b0; limpa = 1'b0; confirma = 1'b0;
    #2;
    test_reset();
    test_convert_1234();
    test_leading_zeros();
    test_apaga_full();
    test_errors();
    test_abort();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
